sine_phase_gen: RTL and testbench

Phase-accumulator address generator that drives the sine sample memory's 9-bit read address.
- A programmable frequency tuning word (FTW) is added to an accumulator once per sample tick.
- The accumulator's top bits form the table address.
- A latency-matched sample_valid pulse tells the downstream output stage when the memory's 10-bit read data is stable.

---
 rtl/sine_pkg.sv | 15 +
 rtl/sine_tick_div.sv | 36 +++
 rtl/sine_phase_gen.sv | 114 +++++++++++
 tb/tb_sine_phase_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Types and constants shared by the sine phase generator and the sine sample memory.
package sine_pkg;

  localparam int ADDR_WIDTH   = 9;
  localparam int SAMPLE_WIDTH = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  typedef logic [ADDR_WIDTH-1:0]   addr_t;
  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sine_tick_div.sv
// Sample-rate divider: raises tick on the last count of each TICK_DIV-cycle period while running.
module sine_tick_div #(
  parameter int TICK_DIV = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = run && (count_r == LAST);

  // Period counter; clear restarts the period even while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (run) begin
      if (count_r == LAST) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/sine_phase_gen.sv
// Phase-accumulator address generator for the sine sample memory, with a one-deep
// tuning-word slot and a latency-matched sample_valid pulse.
module sine_phase_gen #(
  parameter int                   ACC_WIDTH   = 24,
  parameter int                   ADDR_WIDTH  = 9,
  parameter int                   TICK_DIV    = 64,
  parameter int                   MEM_LATENCY = 3,
  parameter logic [ACC_WIDTH-1:0] RESET_FTW   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  phase_clear,
  input  logic [ACC_WIDTH-1:0]  ftw_data,
  input  logic                  ftw_valid,
  output logic                  ftw_ready,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  sample_tick,
  output logic                  sample_valid
);

  import sine_pkg::*;

  gen_state_t             state_r;
  logic                   run_s;
  logic                   tick_s;
  logic                   accept_s;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [ACC_WIDTH-1:0]   active_ftw_r;
  logic [ACC_WIDTH-1:0]   pending_r;
  logic                   pending_full_r;
  logic [ACC_WIDTH-1:0]   ftw_used_s;
  logic                   upd_r;
  logic [MEM_LATENCY-1:0] vpipe_r;

  assign run_s        = (state_r == RUN);
  assign accept_s     = ftw_valid && !pending_full_r;
  assign ftw_ready    = !pending_full_r;
  assign read_address = acc_r[ACC_WIDTH-1 -: ADDR_WIDTH];
  assign sample_tick  = tick_s;
  assign sample_valid = vpipe_r[MEM_LATENCY-1];

  // A waiting word takes effect on the very tick that consumes it
  always_comb begin
    if (pending_full_r) begin
      ftw_used_s = pending_r;
    end else begin
      ftw_used_s = active_ftw_r;
    end
  end

  sine_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_s),
    .clear (phase_clear),
    .tick  (tick_s)
  );

  // Run/idle state follows enable with one cycle of registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= enable ? RUN : IDLE;
        RUN:     state_r <= enable ? RUN : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Accumulator and tuning-word slot; clear beats a coincident tick and leaves the slot alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r          <= {ACC_WIDTH{1'b0}};
      active_ftw_r   <= RESET_FTW;
      pending_r      <= {ACC_WIDTH{1'b0}};
      pending_full_r <= 1'b0;
    end else begin
      if (phase_clear) begin
        acc_r <= {ACC_WIDTH{1'b0}};
      end else if (tick_s) begin
        acc_r <= acc_r + ftw_used_s;
      end else begin
        acc_r <= acc_r;
      end
      // Accept needs an empty slot, apply needs a full one: never both on one edge
      if (tick_s && !phase_clear && pending_full_r) begin
        active_ftw_r   <= pending_r;
        pending_full_r <= 1'b0;
      end else if (accept_s) begin
        pending_r      <= ftw_data;
        pending_full_r <= 1'b1;
      end else begin
        pending_full_r <= pending_full_r;
      end
    end
  end

  // upd_r marks the edge that moved read_address; the pipe then counts memory edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_r   <= 1'b0;
      vpipe_r <= {MEM_LATENCY{1'b0}};
    end else begin
      upd_r   <= tick_s || phase_clear;
      vpipe_r <= (vpipe_r << 1'b1) | MEM_LATENCY'(upd_r);
    end
  end

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed bench for sine_phase_gen: a phase/slot tracker pushes expected addresses into a
// scoreboard on every tick or clear, and a monitor pops them when sample_valid fires.
module tb_sine_phase_gen;

  localparam int          DIV     = 4;
  localparam int          LAT     = 3;
  localparam logic [23:0] RST_FTW = 24'h008000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        phase_clear;
  logic [23:0] ftw_data;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [8:0]  read_address;
  logic        sample_tick;
  logic        sample_valid;

  sine_phase_gen #(
    .ACC_WIDTH   (24),
    .ADDR_WIDTH  (9),
    .TICK_DIV    (DIV),
    .MEM_LATENCY (LAT),
    .RESET_FTW   (RST_FTW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .phase_clear  (phase_clear),
    .ftw_data     (ftw_data),
    .ftw_valid    (ftw_valid),
    .ftw_ready    (ftw_ready),
    .read_address (read_address),
    .sample_tick  (sample_tick),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  typedef struct {
    logic [8:0] addr;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [23:0] exp_phase;
  logic [23:0] bk_active;
  logic [23:0] bk_pend;
  logic        bk_pfull;
  int          last_tick;
  bit          period_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: each valid pulse must match the oldest expected update
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sample_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("valid_with_empty_sb", {31'd0, sample_valid}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("valid_time", cyc_n, mon_e.due);
          chk("valid_addr", {23'd0, read_address}, {23'd0, mon_e.addr});
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc_n) begin
        chk("missing_valid", {31'd0, sample_valid}, 32'd1);
        mon_e = sb_q.pop_front();
      end
    end
  end

  // One clock of stimulus: check state, predict the coming edge, then advance
  task automatic edge_step();
    exp_t        t;
    logic [23:0] ftw;
    logic        rdy;
    rdy = !bk_pfull;
    chk("addr", {23'd0, read_address}, {23'd0, exp_phase[23:15]});
    chk("ftw_ready", {31'd0, ftw_ready}, {31'd0, rdy});
    if (sample_tick === 1'b1) begin
      if (period_chk && last_tick >= 0) chk("tick_period", cyc_n - last_tick, DIV);
      last_tick = cyc_n;
    end
    if (phase_clear) begin
      exp_phase = 24'd0;
      t.addr = 9'd0;
      t.due  = cyc_n + 1 + LAT;
      sb_q.push_back(t);
    end else if (sample_tick === 1'b1) begin
      ftw = bk_pfull ? bk_pend : bk_active;
      if (bk_pfull) begin
        bk_active = bk_pend;
        bk_pfull  = 1'b0;
      end
      exp_phase = exp_phase + ftw;
      t.addr = exp_phase[23:15];
      t.due  = cyc_n + 1 + LAT;
      sb_q.push_back(t);
    end
    if (ftw_valid && rdy) begin
      bk_pend  = ftw_data;
      bk_pfull = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int  n;
    int  ticks;
    bit  saw_wrap;
    logic [8:0] prev_addr;

    rst_n       = 1'b0;
    enable      = 1'b0;
    phase_clear = 1'b0;
    ftw_valid   = 1'b0;
    ftw_data    = 24'd0;
    exp_phase   = 24'd0;
    bk_active   = RST_FTW;
    bk_pend     = 24'd0;
    bk_pfull    = 1'b0;
    last_tick   = -1;
    period_chk  = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_addr",   {23'd0, read_address}, 32'd0);
    chk("rst_tick",   {31'd0, sample_tick},  32'd0);
    chk("rst_valid",  {31'd0, sample_valid}, 32'd0);
    chk("rst_ready",  {31'd0, ftw_ready},    32'd1);
    rst_n = 1'b1;

    // 1: run with the reset tuning word, address steps by one per tick
    enable = 1'b1;
    repeat (24) edge_step();

    // 2: word into an empty slot, then a second word that must wait for the tick
    ftw_data  = 24'h010000;
    ftw_valid = 1'b1;
    edge_step();
    ftw_data = 24'h018000;
    n = 0;
    while (ftw_ready !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    chk("ready_low_span", {31'd0, (n >= 1 && n <= DIV)}, 32'd1);
    edge_step();
    ftw_valid = 1'b0;
    repeat (16) edge_step();

    // 3: fractional step 1.5 addresses per tick over 350 ticks, wrapping the table
    n = 0;
    while (ftw_ready !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    ftw_data  = 24'h00C000;
    ftw_valid = 1'b1;
    edge_step();
    ftw_valid = 1'b0;
    ticks     = 0;
    saw_wrap  = 1'b0;
    prev_addr = read_address;
    for (int i = 0; i < 350 * DIV; i++) begin
      if (sample_tick === 1'b1) ticks++;
      edge_step();
      if (read_address < prev_addr) saw_wrap = 1'b1;
      prev_addr = read_address;
    end
    chk("tick_count_350", ticks, 350);
    chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);

    // 4: clear coincident with a tick while a word is pending
    n = 0;
    while (ftw_ready !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    ftw_data  = 24'h004000;
    ftw_valid = 1'b1;
    edge_step();
    ftw_valid = 1'b0;
    n = 0;
    while (sample_tick !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    chk("tick_before_clear", {31'd0, sample_tick}, 32'd1);
    phase_clear = 1'b1;
    edge_step();
    phase_clear = 1'b0;
    chk("clear_addr", {23'd0, read_address}, 32'd0);
    chk("pending_kept", {31'd0, ftw_ready}, 32'd0);
    repeat (16) edge_step();

    // 5: freeze with the counter landing on 2, then resume
    period_chk = 1'b0;
    n = 0;
    while (sample_tick !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    edge_step();
    edge_step();
    enable = 1'b0;
    edge_step();
    repeat (8) begin
      chk("idle_no_tick", {31'd0, sample_tick}, 32'd0);
      edge_step();
    end
    enable = 1'b1;
    n = 0;
    do begin
      edge_step();
      n++;
    end while (sample_tick !== 1'b1 && n < 10);
    chk("reenable_tick_latency", n, 2);
    edge_step();
    period_chk = 1'b1;
    repeat (8) edge_step();

    // 6: asynchronous reset mid-cycle with a pending word and a valid in flight
    n = 0;
    while (ftw_ready !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    ftw_data  = 24'h020000;
    ftw_valid = 1'b1;
    edge_step();
    ftw_valid = 1'b0;
    n = 0;
    while (sample_tick !== 1'b1 && n < 10) begin
      edge_step();
      n++;
    end
    edge_step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  {23'd0, read_address}, 32'd0);
    chk("arst_tick",  {31'd0, sample_tick},  32'd0);
    chk("arst_valid", {31'd0, sample_valid}, 32'd0);
    chk("arst_ready", {31'd0, ftw_ready},    32'd1);
    sb_q.delete();
    exp_phase = 24'd0;
    bk_active = RST_FTW;
    bk_pfull  = 1'b0;
    last_tick = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) edge_step();

    enable = 1'b0;
    repeat (8) edge_step();
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
